// File: rtl/markov_song_generator_pkg.sv
// -----------------------------------------------------------------------------
// markov_song_generator_pkg
// Shared widths, entry field layout, FSM state type and field-extraction helpers
// for the Markov song generator. Every other file of the block imports this.
//   Entry layout (LSB first): count, event 0, event 1, ... event SEQUENCE_LEN-1.
//   Event layout: {note, delay}, note in the MSBs.
// -----------------------------------------------------------------------------
package markov_song_generator_pkg;

    localparam int NOTE_BIT_LEN     = 4;
    localparam int DELAY_BIT_LEN    = 4;
    localparam int SEQUENCE_LEN     = 2;
    localparam int SEQ_CNT_BIT_LEN  = 4;
    localparam int MARKOV_CHAIN_LEN = 4;
    localparam int SONG_OUTPUT_LEN  = 6;

    localparam int EV_W    = NOTE_BIT_LEN + DELAY_BIT_LEN;
    localparam int ENTRY_W = SEQUENCE_LEN * EV_W + SEQ_CNT_BIT_LEN;
    localparam int TABLE_W = ENTRY_W * MARKOV_CHAIN_LEN;
    localparam int IDX_W   = $clog2(MARKOV_CHAIN_LEN);
    localparam int TOT_W   = SEQ_CNT_BIT_LEN + IDX_W;
    localparam int POS_W   = $clog2(SEQUENCE_LEN + 1);
    localparam int CNT_W   = $clog2(SONG_OUTPUT_LEN + 1);

    // Field offsets inside one entry
    localparam int CNT_LSB = 0;
    localparam int EV0_LSB = SEQ_CNT_BIT_LEN;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    typedef logic [EV_W-1:0]    event_t;
    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SUM    = 3'd1,
        ST_REDUCE = 3'd2,
        ST_SCAN   = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Occurrence count of an entry
    function automatic logic [SEQ_CNT_BIT_LEN-1:0] entry_count(input entry_t e);
        return e[CNT_LSB +: SEQ_CNT_BIT_LEN];
    endfunction

    // Event k of an entry (k = 0 is the first event of the sequence)
    function automatic event_t entry_event(input entry_t e, input logic [POS_W-1:0] k);
        return e[EV0_LSB + int'(k) * EV_W +: EV_W];
    endfunction

endpackage

// File: rtl/markov_song_generator_if.sv
// -----------------------------------------------------------------------------
// markov_song_generator_if
// Valid/ready event stream produced by the song generator.
//   out_event : {note, delay} of the presented event
//   out_valid : out_event is valid
//   out_ready : downstream accepts the event this cycle
//   out_last  : presented event is the final one of the run
// master = generator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface markov_song_generator_if;
    import markov_song_generator_pkg::*;

    event_t out_event;
    logic   out_valid;
    logic   out_ready;
    logic   out_last;

    modport master (
        output out_event,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_event,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/markov_song_generator_lfsr16.sv
// -----------------------------------------------------------------------------
// markov_lfsr16
// 16-bit Galois LFSR (mask 16'hB400) used as the random source for picks.
//   clk, rst_n : clock, async active-low reset (state resets to 16'hACE1)
//   load_i     : load seed_i (a zero seed is replaced by 16'hACE1 so the
//                register can never lock up in the all-zero state)
//   seed_i     : seed value
//   step_i     : advance one step
//   state_o    : current 16-bit state
// -----------------------------------------------------------------------------
module markov_lfsr16
    import markov_song_generator_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next LFSR state: load has priority over step
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 16'h0000) ? LFSR_DEFAULT : seed_i;
        end else if (step_i) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_MASK : 16'h0000);
        end else begin
            state_d = state_q;
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LFSR_DEFAULT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/markov_song_generator.sv
// -----------------------------------------------------------------------------
// markov_song_generator
// Composes a song from a learned Markov chain table. Each step sums the counts
// of the entries whose first event continues the last emitted event, draws a
// count-weighted random entry and streams its events; the first event of a
// conditioned pick is skipped because it repeats the previous event.
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle pulse, accepted only when idle
//   seed       : LFSR seed, captured on accepted start
//   markov_in  : chain table, entry i at [i*ENTRY_W +: ENTRY_W], captured on start
//   out_if     : event stream (out_event/out_valid/out_ready/out_last)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at end of run
//   empty_err  : all counts zero; held until the next accepted start
// -----------------------------------------------------------------------------
module markov_song_generator
    import markov_song_generator_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [15:0]             seed,
    input  logic [TABLE_W-1:0]      markov_in,
    markov_song_generator_if.master out_if,
    output logic                    busy,
    output logic                    done,
    output logic                    empty_err
);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MARKOV_CHAIN_LEN - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(SEQUENCE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SONG_OUTPUT_LEN - 1);
    localparam logic [15:0]      R_MASK    = 16'((32'd1 << TOT_W) - 32'd1);

    state_e               state_q,     state_d;
    logic [TABLE_W-1:0]   table_q,     table_d;
    logic [IDX_W-1:0]     idx_q,       idx_d;
    logic [TOT_W-1:0]     total_q,     total_d;
    logic [TOT_W-1:0]     r_q,         r_d;
    logic [TOT_W-1:0]     acc_q,       acc_d;
    entry_t               sel_q,       sel_d;
    logic [POS_W-1:0]     pos_q,       pos_d;
    logic [CNT_W-1:0]     emit_cnt_q,  emit_cnt_d;
    event_t               prev_q,      prev_d;
    logic                 have_prev_q, have_prev_d;
    logic                 fallback_q,  fallback_d;
    event_t               event_q,     event_d;
    logic                 valid_q,     valid_d;
    logic                 last_q,      last_d;
    logic                 empty_err_q, empty_err_d;
    logic                 done_q,      done_d;
    logic                 busy_q,      busy_d;

    entry_t               cur_entry_s;
    logic                 elig_s;
    logic [TOT_W-1:0]     cur_cnt_s;
    logic [TOT_W-1:0]     sum_s;
    logic [TOT_W-1:0]     acc_sum_s;
    logic [POS_W-1:0]     first_pos_s;
    logic                 lfsr_load_s;
    logic                 lfsr_step_s;
    logic [15:0]          lfsr_s;

    markov_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (lfsr_load_s),
        .seed_i  (seed),
        .step_i  (lfsr_step_s),
        .state_o (lfsr_s)
    );

    // Entry under the scan index and its eligible (weighted) count
    always_comb begin
        cur_entry_s = table_q[int'(idx_q) * ENTRY_W +: ENTRY_W];
        // fallback or an unconditioned pick admits every entry
        elig_s      = fallback_q || !have_prev_q ||
                      (entry_event(cur_entry_s, POS_W'(0)) == prev_q);
        cur_cnt_s   = elig_s ? {{IDX_W{1'b0}}, entry_count(cur_entry_s)} : {TOT_W{1'b0}};
        sum_s       = total_q + cur_cnt_s;
        acc_sum_s   = acc_q + cur_cnt_s;
        // a conditioned pick already has its first event on the output
        first_pos_s = (have_prev_q && !fallback_q) ? POS_W'(1) : POS_W'(0);
    end

    // FSM next state and datapath updates
    always_comb begin
        state_d     = state_q;
        table_d     = table_q;
        idx_d       = idx_q;
        total_d     = total_q;
        r_d         = r_q;
        acc_d       = acc_q;
        sel_d       = sel_q;
        pos_d       = pos_q;
        emit_cnt_d  = emit_cnt_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        fallback_d  = fallback_q;
        event_d     = event_q;
        valid_d     = valid_q;
        last_d      = last_q;
        empty_err_d = empty_err_q;
        lfsr_load_s = 1'b0;
        lfsr_step_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    table_d     = markov_in;
                    lfsr_load_s = 1'b1;
                    emit_cnt_d  = {CNT_W{1'b0}};
                    have_prev_d = 1'b0;
                    fallback_d  = 1'b0;
                    prev_d      = {EV_W{1'b0}};
                    empty_err_d = 1'b0;
                    idx_d       = {IDX_W{1'b0}};
                    total_d     = {TOT_W{1'b0}};
                    state_d     = ST_SUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SUM: begin
                total_d = sum_s;
                if (idx_q == IDX_LAST) begin
                    idx_d = {IDX_W{1'b0}};
                    if (sum_s == {TOT_W{1'b0}}) begin
                        total_d = {TOT_W{1'b0}};
                        if (have_prev_q && !fallback_q) begin
                            // dead end: rerun the sum with every entry eligible
                            fallback_d = 1'b1;
                            state_d    = ST_SUM;
                        end else begin
                            empty_err_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end else begin
                        r_d     = TOT_W'(lfsr_s & R_MASK);
                        state_d = ST_REDUCE;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_REDUCE: begin
                // modulo by repeated subtraction, one per cycle
                if (r_q >= total_q) begin
                    r_d = r_q - total_q;
                end else begin
                    lfsr_step_s = 1'b1;
                    acc_d       = {TOT_W{1'b0}};
                    idx_d       = {IDX_W{1'b0}};
                    state_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
                acc_d = acc_sum_s;
                // strict '>' means a zero-count entry can never be the first to pass r;
                // the last-index term only guards against a corrupted total
                if ((acc_sum_s > r_q) || (idx_q == IDX_LAST)) begin
                    sel_d   = cur_entry_s;
                    pos_d   = first_pos_s;
                    event_d = entry_event(cur_entry_s, first_pos_s);
                    valid_d = 1'b1;
                    last_d  = (emit_cnt_q == CNT_LAST);
                    state_d = ST_EMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_EMIT: begin
                if (valid_q && out_if.out_ready) begin
                    prev_d      = event_q;
                    have_prev_d = 1'b1;
                    emit_cnt_d  = emit_cnt_q + CNT_W'(1);
                    if (emit_cnt_q == CNT_LAST) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        event_d = {EV_W{1'b0}};
                        state_d = ST_DONE;
                    end else if (pos_q == POS_LAST) begin
                        valid_d    = 1'b0;
                        last_d     = 1'b0;
                        event_d    = {EV_W{1'b0}};
                        fallback_d = 1'b0;
                        idx_d      = {IDX_W{1'b0}};
                        total_d    = {TOT_W{1'b0}};
                        state_d    = ST_SUM;
                    end else begin
                        pos_d   = pos_q + POS_W'(1);
                        event_d = entry_event(sel_q, pos_q + POS_W'(1));
                        last_d  = (emit_cnt_d == CNT_LAST);
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            table_q     <= {TABLE_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            total_q     <= {TOT_W{1'b0}};
            r_q         <= {TOT_W{1'b0}};
            acc_q       <= {TOT_W{1'b0}};
            sel_q       <= {ENTRY_W{1'b0}};
            pos_q       <= {POS_W{1'b0}};
            emit_cnt_q  <= {CNT_W{1'b0}};
            prev_q      <= {EV_W{1'b0}};
            have_prev_q <= 1'b0;
            fallback_q  <= 1'b0;
            event_q     <= {EV_W{1'b0}};
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            empty_err_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            idx_q       <= idx_d;
            total_q     <= total_d;
            r_q         <= r_d;
            acc_q       <= acc_d;
            sel_q       <= sel_d;
            pos_q       <= pos_d;
            emit_cnt_q  <= emit_cnt_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            fallback_q  <= fallback_d;
            event_q     <= event_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            empty_err_q <= empty_err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign out_if.out_event = event_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign empty_err        = empty_err_q;

endmodule

// File: doc/markov_song_generator.md
# markov_song_generator

Reads a learned Markov chain table (the output of the Markov learning/merge stages) and composes a new song from it, one note/delay event at a time. Each step draws a count-weighted random sequence whose first event continues the last emitted event, then streams its events over a valid/ready interface. It is the consumer end of the chain table, sitting after the merge stage and producing the generated song.

## Interface
- NOTE_BIT_LEN, 4: note field width.
- DELAY_BIT_LEN, 4: delay field width.
- SEQUENCE_LEN, 2: events per chain entry (≥2).
- SEQ_CNT_BIT_LEN, 4: occurrence count width.
- MARKOV_CHAIN_LEN, 4: entries in the table.
- SONG_OUTPUT_LEN, 6: events to emit per run.
- Derived: EV_W = NOTE_BIT_LEN+DELAY_BIT_LEN; ENTRY_W = SEQUENCE_LEN*EV_W+SEQ_CNT_BIT_LEN; TOT_W = SEQ_CNT_BIT_LEN+clog2(MARKOV_CHAIN_LEN), TOT_W ≤ 16.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  one-cycle pulse; begins a run; ignored unless IDLE.
- seed  in  16  LFSR seed, captured on accepted start.
- markov_in  in  ENTRY_W*MARKOV_CHAIN_LEN  chain table; entry i at [i*ENTRY_W +: ENTRY_W]; captured on accepted start.
- out_event  out  EV_W  {note, delay}, note in MSBs.
- out_valid  out  1  out_event valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with the final event of the run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- empty_err  out  1  high with done when all counts are zero; cleared on next accepted start.

## Operation
- Entry layout: count in bits [SEQ_CNT_BIT_LEN-1:0]; event k at [SEQ_CNT_BIT_LEN + k*EV_W +: EV_W], k=0 is first.
- LFSR: 16-bit Galois, mask 16'hB400, shifts once per pick (on leaving REDUCE). seed==0 is replaced by 16'hACE1.
- States: IDLE → SUM → REDUCE → SCAN → EMIT → (SUM | DONE) → IDLE.
- IDLE: on start, latch table and seed, clear emit counter, clear have_prev; → SUM.
- SUM: one entry per cycle; entry eligible if have_prev==0, or its event 0 equals prev_event. total += eligible counts. After last entry: if total==0 and have_prev==1, set fallback (all entries eligible) and rerun SUM; if total==0 and have_prev==0 → DONE with empty_err=1.
- REDUCE: r = lfsr[TOT_W-1:0]; while r ≥ total, r -= total (one subtract per cycle); then → SCAN.
- SCAN: one entry per cycle, acc += eligible count; first entry with acc > r is selected → EMIT. Zero-count entries are never selected.
- EMIT: start index = 1 if the pick was conditioned (have_prev==1 and not fallback), else 0. Present events in order; advance on out_valid&&out_ready. Each accepted event updates prev_event, sets have_prev, increments emit counter. When counter reaches SONG_OUTPUT_LEN → DONE (sequence truncated). When the sequence is exhausted → SUM (fallback cleared).
- DONE: done=1 for one cycle; → IDLE.

## Timing
- Reset: all outputs 0, state IDLE, LFSR 16'hACE1, counters 0.
- start→busy: busy high the cycle after accepted start.
- SUM: MARKOV_CHAIN_LEN cycles (×2 with fallback). REDUCE: 1 + number of subtracts. SCAN: ≤ MARKOV_CHAIN_LEN cycles.
- out_valid registered; out_event/out_last stable while out_valid && !out_ready. Next event may be presented the cycle after a handshake (back-to-back within a sequence).
- out_last high exactly with event SONG_OUTPUT_LEN; done pulses the cycle after its handshake.
- start while busy: ignored, no effect on run.
- rst_n low mid-run: immediate abort, outputs to reset values, no done.

## Structure
- Defines.v holds shared widths (NOTE_BIT_LEN, DELAY_BIT_LEN, SEQUENCE_LEN, SEQ_CNT_BIT_LEN, MARKOV_CHAIN_LEN) and entry field offsets; SONG_OUTPUT_LEN is added there.
- Sub-module: markov_lfsr16 (seed load, step enable, 16-bit state out).

## Test plan
Defaults; events written as hex {note,delay}.
- Entry0 = {31,52} cnt 3, others cnt 0 -> emits 31 52 31 52 31 52 (fallback each step), out_last on 6th, one done, empty_err=0.
- Entries {11,22} c1, {22,33} c5, {33,11} c2, entry3 c0 -> every event after the first sequence continues the cycle 11→22→33→11; 6 events, each successor's first event equals previous event.
- All counts 0 -> no out_valid; done pulse with empty_err=1; busy low afterwards.
- Hold out_ready low 10 cycles mid-run -> out_valid=1 and out_event unchanged throughout; resumes on release with no event lost or repeated.
- Assert rst_n low during EMIT -> outputs 0 immediately; new start after release runs full 6 events.
- Pulse start during EMIT -> ignored; run completes normally with exactly one done.
